// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, error codes and timing helper
// Purpose: FSM state enum, err_code encodings and microsecond-to-cycle
//          conversion shared by the PS/2 host transmitter and receiver.
// Ports:   none (package).
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NOACK   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic int unsigned us_to_cyc(input int unsigned us,
                                            input int unsigned cyc_per_us);
    return us * cyc_per_us;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - request/status bundle of the PS/2 host transmitter
// Purpose: groups the byte request and completion status signals.
// Ports:   tx_start/tx_data (request), tx_busy/tx_done/tx_err/err_code (status).
//          master = requester (control FSM), slave = ps2_host_tx.
interface ps2_host_tx_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;

  modport master (
    output tx_start, tx_data,
    input  tx_busy, tx_done, tx_err, err_code
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, tx_done, tx_err, err_code
  );

endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchroniser with falling-edge detect for one PS/2 line
// Purpose: brings an asynchronous open-drain line into the clk domain.
// Ports:   clk, reset_n (async, active low; stages reset to 1 = released line),
//          line_in (raw line), line_sync (synchronised level),
//          fall (one-cycle pulse on a synchronised 1->0 transition).
module ps2_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_sync = sync_q;
  assign fall      = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - parametrised PS/2 host-to-device byte transmitter
// Purpose: request-to-send timing, LSB-first data + odd parity + stop,
//          device ack check and protocol timeout, open-drain line drive.
// Ports:   clk, reset_n (async, active low),
//          tx (ps2_host_tx_if.slave: tx_start, tx_data, tx_busy, tx_done,
//          tx_err, err_code), ps2clk / ps2data (open-drain, 0 or z).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned SETUP_US    = 5,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input  logic         clk,
  input  logic         reset_n,
  ps2_host_tx_if.slave tx,
  inout  wire          ps2clk,
  inout  wire          ps2data
);

  localparam int unsigned CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned INHIBIT_CYC = us_to_cyc(INHIBIT_US, CYC_PER_US);
  localparam int unsigned SETUP_CYC   = us_to_cyc(SETUP_US, CYC_PER_US);
  localparam int unsigned TIMEOUT_CYC = us_to_cyc(TIMEOUT_US, CYC_PER_US);
  // One timer serves all three intervals, so size it for the longest.
  localparam int unsigned MAX_CYC0    = (INHIBIT_CYC > SETUP_CYC) ? INHIBIT_CYC : SETUP_CYC;
  localparam int unsigned MAX_CYC     = (TIMEOUT_CYC > MAX_CYC0) ? TIMEOUT_CYC : MAX_CYC0;
  localparam int          TW          = $clog2(MAX_CYC + 1);

  // Compare against N-1 so the registered effect lands exactly N cycles in.
  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] SETUP_LAST   = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  ps2_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          clk_sync, clk_fall;
  logic          data_sync, data_fall;
  logic          parity;
  logic          timeout;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_in   (ps2clk),
    .line_sync (clk_sync),
    .fall      (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_in   (ps2data),
    .line_sync (data_sync),
    .fall      (data_fall)
  );

  assign parity  = ~^byte_q;
  assign timeout = (timer_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      byte_q     <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_q     <= byte_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    byte_d     = byte_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (tx.tx_start) begin
          byte_d     = tx.tx_data;
          err_code_d = ERR_NONE;
          state_d    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (timer_q == INHIBIT_LAST) begin
          timer_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (timer_q == SETUP_LAST) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      default: begin
        // Device-clocked phase: timeout wins over a same-cycle edge.
        if (timeout) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          case (state_q)
            ST_DATA: begin
              if (clk_fall) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
              end
            end
            ST_PARITY: if (clk_fall) state_d = ST_STOP;
            ST_STOP:   if (clk_fall) state_d = ST_ACK;
            ST_ACK: begin
              if (clk_fall) begin
                if (!data_sync) begin
                  state_d = ST_WAIT_IDLE;
                end else begin
                  state_d    = ST_IDLE;
                  err_d      = 1'b1;
                  err_code_d = ERR_NOACK;
                end
              end
            end
            ST_WAIT_IDLE: begin
              if (clk_sync && data_sync) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    // Line enables and busy are registered from the next state so the
    // pins change on the same edge as the state and reset releases them.
    clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
    case (state_d)
      ST_REQ:    data_oe_d = 1'b1;
      ST_DATA:   data_oe_d = ~byte_d[bit_cnt_d];
      ST_PARITY: data_oe_d = ~parity;
      default:   data_oe_d = 1'b0;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign ps2clk  = clk_oe_q  ? 1'b0 : 1'bz;
  assign ps2data = data_oe_q ? 1'b0 : 1'bz;

  assign tx.tx_busy  = busy_q;
  assign tx.tx_done  = done_q;
  assign tx.tx_err   = err_q;
  assign tx.err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned INH    = 100;
  localparam int unsigned SET    = 5;
  localparam int unsigned TMO    = 2000;

  typedef enum int {M_ACK, M_NOACK, M_NOCLK, M_INJECT, M_RESET} mode_e;

  typedef struct {
    logic [7:0] data;
    mode_e      mode;
    logic       exp_par;
    int         exp_done;
    logic [1:0] exp_code;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wire  ps2clk;
  wire  ps2data;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  assign ps2clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2data = dev_data_low ? 1'b0 : 1'bz;
  pullup (ps2clk);
  pullup (ps2data);

  ps2_host_tx_if txif ();

  ps2_host_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .INHIBIT_US  (INH),
    .SETUP_US    (SET),
    .TIMEOUT_US  (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tx      (txif),
    .ps2clk  (ps2clk),
    .ps2data (ps2data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: the parity bit makes the count of ones over 9 bits odd.
  function automatic logic model_parity(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  int         done_cnt = 0;
  int         err_cnt = 0;
  int         pulse_bad = 0;
  logic [1:0] last_code = 2'b00;
  logic       prev_done = 1'b0;
  logic       prev_err = 1'b0;

  // A good pulse is a single cycle and coincides with busy low.
  always @(negedge clk) begin
    if (txif.tx_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (prev_done || txif.tx_busy !== 1'b0) pulse_bad <= pulse_bad + 1;
    end
    if (txif.tx_err === 1'b1) begin
      err_cnt   <= err_cnt + 1;
      last_code <= txif.err_code;
      if (prev_err || txif.tx_busy !== 1'b0) pulse_bad <= pulse_bad + 1;
    end
    prev_done <= (txif.tx_done === 1'b1);
    prev_err  <= (txif.tx_err === 1'b1);
  end

  task automatic send_frame(input logic [7:0] d, input mode_e mode, input logic exp_par,
                            input int exp_done, input logic [1:0] exp_code);
    int         dc0, ec0, pb0, lowc, dlow, k;
    logic [9:0] rx;
    rx = '0;
    k  = 0;
    while (txif.tx_busy !== 1'b0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("idle_before_start", txif.tx_busy, 1'b0);
    dc0 = done_cnt;
    ec0 = err_cnt;
    pb0 = pulse_bad;

    @(negedge clk);
    txif.tx_start = 1'b1;
    txif.tx_data  = d;
    @(negedge clk);
    txif.tx_start = 1'b0;
    txif.tx_data  = 8'($urandom);
    check("busy_after_accept", txif.tx_busy, 1'b1);
    check("err_code_cleared", txif.err_code, ERR_NONE);

    lowc = 0;
    dlow = 0;
    while (ps2clk === 1'b0 && lowc < 1000) begin
      if (ps2data === 1'b0) dlow++;
      lowc++;
      @(negedge clk);
    end
    check("clk_low_cycles", lowc, INH + SET);
    check("start_bit_cycles", dlow, SET);

    if (mode == M_NOCLK) begin
      k = 0;
      while (txif.tx_err !== 1'b1 && k < 3000) begin
        @(negedge clk);
        k++;
      end
      check("timeout_cycles", k, TMO);
      check("timeout_clk_released", ps2clk, 1'b1);
      check("timeout_data_released", ps2data, 1'b1);
      repeat (5) @(negedge clk);
      check("after_timeout_clk", ps2clk, 1'b1);
      check("after_timeout_data", ps2data, 1'b1);
    end else begin
      repeat (20) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        rx[i] = ps2data;
        if (mode == M_INJECT && i == 3) begin
          txif.tx_start = 1'b1;
          txif.tx_data  = 8'hAA;
          @(negedge clk);
          txif.tx_start = 1'b0;
        end
        if (mode == M_RESET && i == 4) begin
          @(posedge clk);
          #2 reset_n = 1'b0;
          #1;
          check("rst_clk_released", ps2clk, 1'b1);
          check("rst_data_released", ps2data, 1'b1);
          check("rst_busy", txif.tx_busy, 1'b0);
          check("rst_done", txif.tx_done, 1'b0);
          check("rst_err", txif.tx_err, 1'b0);
          check("rst_code", txif.err_code, ERR_NONE);
          repeat (3) @(negedge clk);
          reset_n = 1'b1;
          repeat (2) @(negedge clk);
          return;
        end
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
      end
      check("rx_byte", rx[7:0], d);
      check("rx_parity", rx[8], exp_par);
      check("rx_stop", rx[9], 1'b1);
      if (mode != M_NOACK) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (3) @(negedge clk);
      dev_data_low = 1'b0;
    end

    k = 0;
    while (done_cnt == dc0 && err_cnt == ec0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - dc0, exp_done);
    check("err_pulses", err_cnt - ec0, 1 - exp_done);
    check("pulse_shape", pulse_bad - pb0, 0);
    if (exp_done == 0) check("err_code_value", last_code, exp_code);
    if (mode == M_NOACK) begin
      repeat (10) @(negedge clk);
      check("err_code_held", txif.err_code, ERR_NOACK);
    end
    if (mode == M_INJECT) begin
      repeat (20) @(negedge clk);
      check("inject_no_second_frame", {txif.tx_busy, ps2clk}, 2'b01);
    end
  endtask

  vec_t vecs[5];

  initial begin
    logic [7:0] rd;
    vecs[0] = '{8'hF4, M_ACK,   1'b0, 1, ERR_NONE};
    vecs[1] = '{8'hFF, M_ACK,   1'b1, 1, ERR_NONE};
    vecs[2] = '{8'h00, M_ACK,   1'b1, 1, ERR_NONE};
    vecs[3] = '{8'hF4, M_NOCLK, 1'b0, 0, ERR_TIMEOUT};
    vecs[4] = '{8'h3C, M_NOACK, 1'b1, 0, ERR_NOACK};

    txif.tx_start = 1'b0;
    txif.tx_data  = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", txif.tx_busy, 1'b0);
    check("reset_done", txif.tx_done, 1'b0);
    check("reset_err", txif.tx_err, 1'b0);
    check("reset_code", txif.err_code, ERR_NONE);
    check("reset_clk_line", ps2clk, 1'b1);
    check("reset_data_line", ps2data, 1'b1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++)
      send_frame(vecs[v].data, vecs[v].mode, vecs[v].exp_par, vecs[v].exp_done, vecs[v].exp_code);

    for (int r = 0; r < 6; r++) begin
      rd = 8'($urandom_range(0, 255));
      send_frame(rd, M_ACK, model_parity(rd), 1, ERR_NONE);
    end

    send_frame(8'h5A, M_INJECT, model_parity(8'h5A), 1, ERR_NONE);
    send_frame(8'h33, M_RESET, model_parity(8'h33), 0, ERR_NONE);
    send_frame(8'hED, M_ACK, model_parity(8'hED), 1, ERR_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
